// File: rtl/event_pkg.sv
// Shared types and sizing for the event encoder slice.
package event_pkg;

    localparam int N_EV = 8;
    localparam int W_EV = $clog2(N_EV);

    typedef logic [W_EV-1:0] ev_code_t;

    // Output slot: EMPTY presents nothing, FULL holds one event code.
    typedef enum logic {EMPTY, FULL} slot_state_t;

endpackage

// File: rtl/event_encoder8_3_if.sv
// Output handshake: the encoder (master) presents code/valid, the consumer
// (slave) answers with ready.
interface event_encoder8_3_if #(
    parameter int N = event_pkg::N_EV
);
    localparam int W = $clog2(N);

    logic [W-1:0] code;
    logic         valid;
    logic         ready;

    modport master (output code, output valid, input ready);
    modport slave  (input code, input valid, output ready);

endinterface

// File: rtl/event_encoder8_3_prio_enc.sv
// Combinational priority encoder: index of the highest set bit of vec.
// any is low when vec is all zeros (idx is then 0 and meaningless).
module prio_enc #(
    parameter int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         any
);

    // Scan upward so the highest set bit is the last one to write idx.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        idx = '0;
        any = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (vec[i]) begin
                idx = W'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/event_encoder8_3.sv
// Sequential priority encoder: captures event pulses into a pending set and
// hands them out one at a time, highest index first, over a valid/ready port.
module event_encoder8_3
    import event_pkg::*;
#(
    parameter int N = N_EV,
    localparam int W = $clog2(N)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N-1:0]          req,
    input  logic                  clr_ovf,
    event_encoder8_3_if.master    out_if,
    output logic [N-1:0]          pending,
    output logic                  ovf
);

    slot_state_t  state_q, state_d;
    logic [W-1:0] code_q, code_d;
    logic [N-1:0] pending_q, pending_d;
    logic         ovf_q, ovf_d;

    logic [W-1:0] top_idx;
    logic         any_pending;
    logic         accept;
    logic         load;
    logic [N-1:0] load_mask;
    logic [N-1:0] pending_left;

    prio_enc #(.N(N)) u_prio_enc (
        .vec (pending_q),
        .idx (top_idx),
        .any (any_pending)
    );

    // Next state: slot refill/drain, pending capture after load-clear, overflow flag.
    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        ovf_d     = ovf_q;

        accept = (state_q == FULL) && out_if.ready;
        load   = ((state_q == EMPTY) || accept) && any_pending;

        for (int i = 0; i < N; i++) begin
            load_mask[i] = load && (top_idx == W'(i));
        end

        if (load) begin
            code_d  = top_idx;
            state_d = FULL;
        end else if (accept) begin
            state_d = EMPTY;
        end

        // A request on the bit being loaded this cycle is a fresh event, not a loss.
        pending_left = pending_q & ~load_mask;
        pending_d    = pending_left | req;

        if (clr_ovf) begin
            ovf_d = 1'b0;
        end
        if (|(req & pending_left)) begin
            ovf_d = 1'b1;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (reset) begin
            state_q   <= EMPTY;
            code_q    <= '0;
            pending_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            pending_q <= pending_d;
            ovf_q     <= ovf_d;
        end
    end

    assign out_if.code  = code_q;
    assign out_if.valid = (state_q == FULL);
    assign pending      = pending_q;
    assign ovf          = ovf_q;

endmodule

// File: doc/event_encoder8_3.md
Name: event_encoder8_3

Overview:
- Sequential 8:3 priority encoder.
- Latches single-cycle event pulses on an N-bit request vector into a pending set.
- Presents the highest-index pending event as a binary code on a valid/ready output port, one event per transfer.
- Inverse-direction companion to decoder3_8. Sits between event sources (IRQ lines, status strobes) and a consumer that handles one indexed event at a time.

Parameters:
- N, 8, number of request lines; legal range 2..256.
- W, $clog2(N), code width. Derived; must not be overridden independently.

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, synchronous active-high reset.
- req, input, N, event pulses; each high bit in a cycle is one event.
- clr_ovf, input, 1, clears the ovf flag.
- code, output, W, index of the presented event.
- valid, output, 1, code holds an event.
- ready, input, 1, consumer accepts code when valid && ready.
- pending, output, N, events captured but not yet presented.
- ovf, output, 1, sticky; an event was lost.

Behaviour:
- Reset, on a clk edge with reset=1: pending=0, code=0, valid=0, ovf=0. reset overrides all other inputs that cycle.
- Two-state output FSM:
  - EMPTY: valid=0.
  - FULL: valid=1.
- Slot load condition: load = (EMPTY || (valid && ready)) && |pending.
- On load:
  - code <= highest index i with pending[i]=1 (priority: bit N-1 highest).
  - pending[i] cleared; state FULL.
- (valid && ready) with pending=0 -> EMPTY, valid=0. code keeps its last value; it is a don't-care while invalid.
- FULL with !ready: code and valid held stable. No change permitted until accepted.
- Capture: pending[j] <= pending[j] | req[j] each cycle, evaluated after the load-clear.
  - A req[j] in the same cycle that bit j is loaded leaves pending[j]=1. This is a new event, not overflow.
- Overflow: ovf <= 1 if req[j]=1 while pending[j]=1 and bit j is not being loaded that cycle. The event merges and is lost.
- ovf priority: clr_ovf=1 clears ovf; a simultaneous new overflow wins and sets ovf.
- Latency:
  - req at edge k -> pending bit visible after edge k.
  - When the slot is free, valid=1 with that code after edge k+1.
- Throughput: with ready held high, one event per cycle. No bubbles while pending != 0.
- Multiple simultaneous req bits: all captured, then presented in descending index order on consecutive transfers.
- No combinational path from req or ready to code or valid. All outputs are registered.

Decomposition:
- Shared package event_pkg:
  - localparam N_EV = 8.
  - localparam W_EV = $clog2(N_EV).
  - typedef logic [W_EV-1:0] ev_code_t.
  - typedef enum logic {EMPTY, FULL} slot_state_t.
- One combinational sub-module, prio_enc (N-bit vector -> W-bit index plus any flag, highest bit wins). It is reusable and testable in isolation.
- The top holds the pending register, slot FSM and ovf logic.

Test Plan:
1. Reset with req=8'hFF held -> after release: pending=0, valid=0, ovf=0. Two edges later: valid=1, code=7.
2. Single pulse req=8'b0000_0100, ready=1 -> valid=1, code=2 for exactly one cycle. pending=0 afterwards.
3. Pulse req=8'b1010_0010, ready=1 -> codes 7, 5, 1 on three consecutive cycles, then valid=0.
4. Backpressure: req=8'h01 then req=8'h80 with ready=0 -> code=0 held stable for all stalled cycles, pending=8'h80. Raise ready -> code 0, then code 7.
5. Overflow: req=8'h10 twice while stalled with ready=0 -> ovf=1, and code 4 is presented only once. clr_ovf=1 -> ovf=0 next cycle.
6. Same-cycle requeue and reset mid-operation:
   - req[3] pulses in the cycle bit 3 loads -> code 3 is presented twice, ovf=0.
   - Assert reset while valid=1, pending=8'h0F -> all outputs 0 after the edge.
